// File: rtl/vx_tensor_commit_sequencer_pkg.sv
// Shared types and widths for the tensor commit sequencer.
//   tensor_meta_t : per-uop commit metadata held in the per-warp queues
//   tcs_state_e   : sequencer FSM states
//   wrap_inc      : warp index increment modulo NUM_WARPS
package vx_tensor_commit_sequencer_pkg;

  localparam int unsigned NUM_WARPS  = 4;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned UUID_WIDTH = 16;
  localparam int unsigned NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned NR_BITS    = 6;
  localparam int unsigned NUM_IREGS  = 32;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [NUM_LANES-1:0]  tmask;
    logic [XLEN-1:0]       pc;
    logic                  wb;
  } tensor_meta_t;

  typedef enum logic [1:0] {
    TcsIdle = 2'd0,
    TcsWait = 2'd1,
    TcsBeat = 2'd2
  } tcs_state_e;

  function automatic logic [NW_WIDTH-1:0] wrap_inc(input logic [NW_WIDTH-1:0] w);
    if (32'(w) == NUM_WARPS - 1) begin
      return '0;
    end
    return w + NW_WIDTH'(1);
  endfunction

endpackage

// File: rtl/vx_tensor_commit_sequencer_if.sv
// Execute-side uop handshake and commit-side writeback beat handshake.
//   slave  : sequencer view (takes exe_*, drives commit_*)
//   master : environment view (drives exe_*, takes commit_*)
interface vx_tensor_commit_sequencer_if;
  import vx_tensor_commit_sequencer_pkg::*;

  logic                      exe_valid;
  logic                      exe_ready;
  logic [UUID_WIDTH-1:0]     exe_uuid;
  logic [NW_WIDTH-1:0]       exe_wid;
  logic [NUM_LANES-1:0]      exe_tmask;
  logic [XLEN-1:0]           exe_PC;
  logic                      exe_wb;

  logic                      commit_valid;
  logic                      commit_ready;
  logic [UUID_WIDTH-1:0]     commit_uuid;
  logic [NW_WIDTH-1:0]       commit_wid;
  logic [NUM_LANES-1:0]      commit_tmask;
  logic [XLEN-1:0]           commit_PC;
  logic                      commit_wb;
  logic [NR_BITS-1:0]        commit_rd;
  logic [NUM_LANES*XLEN-1:0] commit_data;
  logic                      commit_tensor;
  logic                      commit_sop;
  logic                      commit_eop;
  logic                      commit_pid;

  modport slave (
    input  exe_valid, exe_uuid, exe_wid, exe_tmask, exe_PC, exe_wb,
    output exe_ready,
    input  commit_ready,
    output commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC, commit_wb,
    output commit_rd, commit_data, commit_tensor, commit_sop, commit_eop, commit_pid
  );

  modport master (
    output exe_valid, exe_uuid, exe_wid, exe_tmask, exe_PC, exe_wb,
    input  exe_ready,
    output commit_ready,
    input  commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC, commit_wb,
    input  commit_rd, commit_data, commit_tensor, commit_sop, commit_eop, commit_pid
  );

endinterface

// File: rtl/vx_tensor_commit_sequencer_rr_select.sv
// Round-robin picker: returns the first set request bit at or after ptr_i, wrapping.
//   req_i   : request vector, one bit per warp
//   ptr_i   : search start index
//   valid_o : any request set
//   idx_o   : selected index
module vx_tensor_commit_sequencer_rr_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  localparam int unsigned SumW = IdxW + 1;

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [IdxW-1:0] off;
  logic [SumW-1:0] sum;

  // Rotate so that bit 0 corresponds to ptr_i; the doubled copy supplies the wrap.
  assign req_dbl = {req_i, req_i};
  assign req_rot = N'(req_dbl >> ptr_i);

  // Scan from the top down so the lowest set offset wins.
  always_comb begin
    valid_o = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        valid_o = 1'b1;
        off     = IdxW'(k);
      end
    end
  end

  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= SumW'(N)) ? IdxW'(sum - SumW'(N)) : IdxW'(sum);

endmodule

// File: rtl/vx_tensor_commit_sequencer.sv
// Multi-warp tensor commit sequencer.
// Buffers tensor uop metadata in per-warp queues, picks warps round-robin, waits LATENCY
// cycles, then emits a NUM_BEATS-beat writeback burst for the selected warp's head uop.
//   clk, reset : clock, synchronous active-high reset
//   bus        : exe_* uop input handshake, commit_* writeback beat output handshake
module vx_tensor_commit_sequencer
  import vx_tensor_commit_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned RD_BASE   = NUM_IREGS
) (
  input logic                         clk,
  input logic                         reset,
  vx_tensor_commit_sequencer_if.slave bus
);

  localparam int unsigned AddrW  = $clog2(QDEPTH);
  localparam int unsigned CountW = AddrW + 1;
  localparam int unsigned CntW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned BeatW  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  // ---------------------------------------------------------------------------
  // Per-warp metadata queues
  // ---------------------------------------------------------------------------
  tensor_meta_t      mem_q    [NUM_WARPS][QDEPTH];
  logic [AddrW-1:0]  wr_ptr_q [NUM_WARPS];
  logic [AddrW-1:0]  wr_ptr_d [NUM_WARPS];
  logic [AddrW-1:0]  rd_ptr_q [NUM_WARPS];
  logic [AddrW-1:0]  rd_ptr_d [NUM_WARPS];
  logic [CountW-1:0] count_q  [NUM_WARPS];
  logic [CountW-1:0] count_d  [NUM_WARPS];

  logic [NUM_WARPS-1:0] full;
  logic [NUM_WARPS-1:0] nonempty;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic                 exe_fire;
  logic                 pop;
  tensor_meta_t         meta_in;
  tensor_meta_t         head;

  // FSM and sequencing state
  tcs_state_e          state_q, state_d;
  logic [NW_WIDTH-1:0] sel_q, sel_d;
  logic [NW_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                last_beat;
  logic                rr_valid;
  logic [NW_WIDTH-1:0] rr_idx;

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      nonempty[w] = (count_q[w] != '0);
      full[w]     = (count_q[w] == CountW'(QDEPTH));
    end
  end

  // Readiness is per warp so a full warp never stalls pushes to other warps.
  assign bus.exe_ready = !full[bus.exe_wid];
  assign exe_fire      = bus.exe_valid && bus.exe_ready;

  assign meta_in = '{
    uuid:  bus.exe_uuid,
    wid:   bus.exe_wid,
    tmask: bus.exe_tmask,
    pc:    bus.exe_PC,
    wb:    bus.exe_wb
  };

  assign head = mem_q[sel_q][rd_ptr_q[sel_q]];

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (exe_fire) begin
      push_vec[bus.exe_wid] = 1'b1;
    end
    if (pop) begin
      pop_vec[sel_q] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      wr_ptr_d[w] = wr_ptr_q[w];
      rd_ptr_d[w] = rd_ptr_q[w];
      count_d[w]  = count_q[w];
      if (push_vec[w]) begin
        wr_ptr_d[w] = wr_ptr_q[w] + AddrW'(1);
      end
      if (pop_vec[w]) begin
        rd_ptr_d[w] = rd_ptr_q[w] + AddrW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push_vec[w] && !pop_vec[w]) begin
        count_d[w] = count_q[w] + CountW'(1);
      end else if (!push_vec[w] && pop_vec[w]) begin
        count_d[w] = count_q[w] - CountW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        wr_ptr_q[w] <= '0;
        rd_ptr_q[w] <= '0;
        count_q[w]  <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        wr_ptr_q[w] <= wr_ptr_d[w];
        rd_ptr_q[w] <= rd_ptr_d[w];
        count_q[w]  <= count_d[w];
      end
    end
  end

  // Storage is not reset; occupancy counters guard every read.
  always_ff @(posedge clk) begin
    if (exe_fire) begin
      mem_q[bus.exe_wid][wr_ptr_q[bus.exe_wid]] <= meta_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Warp selection
  // ---------------------------------------------------------------------------
  vx_tensor_commit_sequencer_rr_select #(
    .N    (NUM_WARPS),
    .IdxW (NW_WIDTH)
  ) u_rr_select (
    .req_i   (nonempty),
    .ptr_i   (rr_ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  assign last_beat = (beat_q == BeatW'(NUM_BEATS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= TcsIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    unique case (state_q)
      TcsIdle: begin
        if (rr_valid) begin
          sel_d   = rr_idx;
          cnt_d   = CntW'(LATENCY);
          beat_d  = '0;
          state_d = (LATENCY == 0) ? TcsBeat : TcsWait;
        end
      end
      TcsWait: begin
        // cnt counts the remaining WAIT cycles including the current one.
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = TcsBeat;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      TcsBeat: begin
        if (bus.commit_ready) begin
          if (last_beat) begin
            beat_d   = '0;
            rr_ptr_d = wrap_inc(sel_q);
            state_d  = TcsIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      default: state_d = TcsIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all commit outputs are zero outside a burst)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.commit_valid  = 1'b0;
    bus.commit_uuid   = '0;
    bus.commit_wid    = '0;
    bus.commit_tmask  = '0;
    bus.commit_PC     = '0;
    bus.commit_wb     = 1'b0;
    bus.commit_rd     = '0;
    bus.commit_data   = '0;
    bus.commit_tensor = 1'b0;
    bus.commit_sop    = 1'b0;
    bus.commit_eop    = 1'b0;
    bus.commit_pid    = 1'b0;
    pop               = 1'b0;
    if (state_q == TcsBeat) begin
      bus.commit_valid  = 1'b1;
      bus.commit_uuid   = head.uuid;
      bus.commit_wid    = head.wid;
      bus.commit_tmask  = head.tmask;
      bus.commit_PC     = head.pc;
      bus.commit_wb     = head.wb;
      bus.commit_rd     = NR_BITS'(RD_BASE) + NR_BITS'(beat_q);
      bus.commit_sop    = (beat_q == '0);
      bus.commit_eop    = last_beat;
      bus.commit_tensor = last_beat;
      pop               = bus.commit_ready && last_beat;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    (push_vec & full & ~pop_vec) == '0);

  a_commit_stable : assert property (@(posedge clk) disable iff (reset)
    (bus.commit_valid && !bus.commit_ready) |=>
      (bus.commit_valid && $stable({bus.commit_uuid, bus.commit_wid, bus.commit_tmask,
                                    bus.commit_PC, bus.commit_wb, bus.commit_rd,
                                    bus.commit_tensor, bus.commit_sop, bus.commit_eop})));

endmodule

// File: tb/tb_vx_tensor_commit_sequencer.sv
// Directed bench for vx_tensor_commit_sequencer: a LATENCY=8/4-beat instance for the
// main scenarios and a LATENCY=0/1-beat instance for the zero-latency corner.
module tb_vx_tensor_commit_sequencer;
  import vx_tensor_commit_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vx_tensor_commit_sequencer_if bus0 ();
  vx_tensor_commit_sequencer_if bus1 ();

  vx_tensor_commit_sequencer #(
    .QDEPTH    (4),
    .LATENCY   (8),
    .NUM_BEATS (4),
    .RD_BASE   (32)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  vx_tensor_commit_sequencer #(
    .QDEPTH    (2),
    .LATENCY   (0),
    .NUM_BEATS (1),
    .RD_BASE   (32)
  ) u_dut_l0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Metadata derived from uuid: tmask = uuid[3:0], PC = {16'h8000, uuid}.
  task automatic push0(input logic [1:0] wid, input logic [15:0] uuid, input logic wb);
    bus0.exe_valid = 1'b1;
    bus0.exe_wid   = wid;
    bus0.exe_uuid  = uuid;
    bus0.exe_tmask = uuid[3:0];
    bus0.exe_PC    = {16'h8000, uuid};
    bus0.exe_wb    = wb;
    #1;
    chk("push_ready", bus0.exe_ready, 1);
    tick();
    bus0.exe_valid = 1'b0;
  endtask

  task automatic wait_valid0();
    int n = 0;
    while (bus0.commit_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("burst_start", bus0.commit_valid, 1);
  endtask

  task automatic chk_beat(input logic [1:0] wid, input logic [15:0] uuid, input logic wb,
                          input int b);
    chk("beat_valid", bus0.commit_valid, 1);
    chk("beat_uuid", bus0.commit_uuid, uuid);
    chk("beat_wid", bus0.commit_wid, wid);
    chk("beat_tmask", bus0.commit_tmask, uuid[3:0]);
    chk("beat_pc", bus0.commit_PC, {16'h8000, uuid});
    chk("beat_wb", bus0.commit_wb, wb);
    chk("beat_rd", bus0.commit_rd, 64'(32 + b));
    chk("beat_sop", bus0.commit_sop, (b == 0));
    chk("beat_eop", bus0.commit_eop, (b == 3));
    chk("beat_tensor", bus0.commit_tensor, (b == 3));
    chk("beat_data0", {bus0.commit_pid, |bus0.commit_data}, 0);
  endtask

  // Full 4-beat burst; optionally holds commit_ready low for stall_n cycles at stall_beat.
  task automatic expect_burst(input logic [1:0] wid, input logic [15:0] uuid, input logic wb,
                              input int stall_beat, input int stall_n);
    wait_valid0();
    for (int b = 0; b < 4; b++) begin
      chk_beat(wid, uuid, wb, b);
      if (b == stall_beat) begin
        bus0.commit_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk_beat(wid, uuid, wb, b);
        end
        bus0.commit_ready = 1'b1;
      end
      tick();
    end
    chk("burst_gap", bus0.commit_valid, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus0.exe_valid = 1'b0;
    bus0.exe_wid   = '0;
    bus0.exe_uuid  = '0;
    bus0.exe_tmask = '0;
    bus0.exe_PC    = '0;
    bus0.exe_wb    = 1'b0;
    bus0.commit_ready = 1'b1;
    bus1.exe_valid = 1'b0;
    bus1.exe_wid   = '0;
    bus1.exe_uuid  = '0;
    bus1.exe_tmask = '0;
    bus1.exe_PC    = '0;
    bus1.exe_wb    = 1'b0;
    bus1.commit_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", bus0.commit_valid, 0);
    chk("rst_ready", bus0.exe_ready, 1);
    chk("rst_rd", bus0.commit_rd, 0);
    chk("rst_sop", bus0.commit_sop, 0);

    // Single uop: beat 0 arrives LATENCY+2 cycles after the accept cycle
    push0(2'd0, 16'h0011, 1'b1);
    repeat (8) tick();
    chk("lat_pre", bus0.commit_valid, 0);
    tick();
    chk("lat_beat0", bus0.commit_valid, 1);
    expect_burst(2'd0, 16'h0011, 1'b1, -1, 0);
    repeat (12) tick();
    chk("single_pop", bus0.commit_valid, 0);

    // Round robin: warp 3 busy, then 2,0,1 queued -> 3,0,1,2
    do_reset();
    push0(2'd3, 16'h0033, 1'b1);
    push0(2'd2, 16'h0022, 1'b1);
    push0(2'd0, 16'h0020, 1'b0);
    push0(2'd1, 16'h0021, 1'b1);
    expect_burst(2'd3, 16'h0033, 1'b1, -1, 0);
    expect_burst(2'd0, 16'h0020, 1'b0, -1, 0);
    expect_burst(2'd1, 16'h0021, 1'b1, -1, 0);
    expect_burst(2'd2, 16'h0022, 1'b1, -1, 0);

    // Backpressure: hold beat 2 for 5 cycles
    do_reset();
    push0(2'd1, 16'h0044, 1'b1);
    expect_burst(2'd1, 16'h0044, 1'b1, 2, 5);

    // Per-warp full: warp 1 filled while warp 0 is in flight
    do_reset();
    push0(2'd0, 16'h0050, 1'b1);
    for (int i = 0; i < 4; i++) push0(2'd1, 16'h0060 + 16'(i), 1'b1);
    bus0.exe_wid = 2'd1;
    #1;
    chk("full_w1", bus0.exe_ready, 0);
    bus0.exe_wid = 2'd3;
    #1;
    chk("other_w3", bus0.exe_ready, 1);
    push0(2'd3, 16'h0070, 1'b1);
    bus0.exe_wid = 2'd1;
    expect_burst(2'd0, 16'h0050, 1'b1, -1, 0);
    chk("still_full_w1", bus0.exe_ready, 0);
    expect_burst(2'd1, 16'h0060, 1'b1, -1, 0);
    chk("ready_after_pop", bus0.exe_ready, 1);
    expect_burst(2'd3, 16'h0070, 1'b1, -1, 0);
    expect_burst(2'd1, 16'h0061, 1'b1, -1, 0);

    // Reset during WAIT
    do_reset();
    push0(2'd2, 16'h0080, 1'b1);
    repeat (3) tick();
    do_reset();
    chk("rstw_valid", bus0.commit_valid, 0);
    for (int w = 0; w < 4; w++) begin
      bus0.exe_wid = 2'(w);
      #1;
      chk("rstw_ready", bus0.exe_ready, 1);
    end
    repeat (12) tick();
    chk("rstw_discard", bus0.commit_valid, 0);

    // Reset during BEAT
    push0(2'd1, 16'h0090, 1'b1);
    expect_burst(2'd1, 16'h0090, 1'b1, -1, 0);
    push0(2'd2, 16'h0091, 1'b1);
    wait_valid0();
    tick();
    chk("rstb_mid_rd", bus0.commit_rd, 33);
    do_reset();
    chk("rstb_valid", bus0.commit_valid, 0);
    chk("rstb_uuid", bus0.commit_uuid, 0);
    chk("rstb_rd", bus0.commit_rd, 0);
    for (int w = 0; w < 4; w++) begin
      bus0.exe_wid = 2'(w);
      #1;
      chk("rstb_ready", bus0.exe_ready, 1);
    end
    repeat (12) tick();
    chk("rstb_discard", bus0.commit_valid, 0);
    push0(2'd1, 16'h0094, 1'b0);
    expect_burst(2'd1, 16'h0094, 1'b0, -1, 0);

    // LATENCY=0, NUM_BEATS=1 instance
    bus1.exe_valid = 1'b1;
    bus1.exe_wid   = 2'd2;
    bus1.exe_uuid  = 16'h00b0;
    bus1.exe_tmask = 4'hb;
    bus1.exe_PC    = 32'h0000_1234;
    bus1.exe_wb    = 1'b1;
    #1;
    chk("l0_ready", bus1.exe_ready, 1);
    tick();
    bus1.exe_valid = 1'b0;
    chk("l0_select_cycle", bus1.commit_valid, 0);
    tick();
    chk("l0_valid", bus1.commit_valid, 1);
    chk("l0_sop", bus1.commit_sop, 1);
    chk("l0_eop", bus1.commit_eop, 1);
    chk("l0_tensor", bus1.commit_tensor, 1);
    chk("l0_rd", bus1.commit_rd, 32);
    chk("l0_uuid", bus1.commit_uuid, 16'h00b0);
    chk("l0_wid", bus1.commit_wid, 2);
    chk("l0_pc", bus1.commit_PC, 32'h0000_1234);
    tick();
    chk("l0_done", bus1.commit_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
